// File: rtl/bus_pkg.sv
// Shared encodings for the 68000 bus cycle sequencer.
// FSM states, region codes and address map constants.
package bus_pkg;

  typedef logic [2:0] region_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_STEP   = 3'd3;
  localparam logic [2:0] ST_ACK    = 3'd4;
  localparam logic [2:0] ST_BERR   = 3'd5;

  localparam region_t RG_NONE  = 3'd0;
  localparam region_t RG_SRAM  = 3'd1;
  localparam region_t RG_PROM  = 3'd2;
  localparam region_t RG_IO    = 3'd3;
  localparam region_t RG_IACK  = 3'd4;
  localparam region_t RG_UNMAP = 3'd5;

  localparam logic [3:0] AREA_LOW  = 4'h0;
  localparam logic [3:0] AREA_IO   = 4'h1;
  localparam logic [3:0] AREA_PROM = 4'hF;
  localparam logic [2:0] FC_IACK   = 3'b111;

endpackage

// File: rtl/bus_cycle_sequencer_if.sv
// CPU-side bus signals of the cycle sequencer.
// master = CPU/board side, slave = sequencer.
interface bus_cycle_sequencer_if;
  import bus_pkg::*;

  logic        AS_IN;
  logic        UDS_IN;
  logic        LDS_IN;
  logic        WR_IN;
  logic [23:0] ADDR_IN;
  logic [2:0]  MPU_STATUS_CODE_IN;
  logic        BOOTSTRAPPED_IN;
  logic        DEV_READY_IN;
  logic        STEPEN_IN;
  logic        STEP_IN;
  logic        DATA_ACK;
  logic        INT_AUTOVEC_ACK;
  logic        BUS_ERROR_ACK;
  region_t     CYCLE_REGION;
  logic        TIMEOUT_FLAG;

  modport master (
    output AS_IN, UDS_IN, LDS_IN, WR_IN, ADDR_IN,
    output MPU_STATUS_CODE_IN, BOOTSTRAPPED_IN,
    output DEV_READY_IN, STEPEN_IN, STEP_IN,
    input  DATA_ACK, INT_AUTOVEC_ACK, BUS_ERROR_ACK,
    input  CYCLE_REGION, TIMEOUT_FLAG
  );

  modport slave (
    input  AS_IN, UDS_IN, LDS_IN, WR_IN, ADDR_IN,
    input  MPU_STATUS_CODE_IN, BOOTSTRAPPED_IN,
    input  DEV_READY_IN, STEPEN_IN, STEP_IN,
    output DATA_ACK, INT_AUTOVEC_ACK, BUS_ERROR_ACK,
    output CYCLE_REGION, TIMEOUT_FLAG
  );

endinterface

// File: rtl/bus_region_decoder.sv
// Combinational bus cycle classifier.
// Also usable by the chip-select logic.
module bus_region_decoder
  import bus_pkg::*;
(
  input  logic [23:0] addr,
  input  logic [2:0]  fc,
  input  logic        wr,
  input  logic        boot,
  output region_t     region
);

  logic       iack;
  logic [3:0] area;
  logic [2:0] lvl;
  logic       unused_a0;

  assign iack      = (fc == FC_IACK);
  assign area      = addr[23:20];
  assign lvl       = addr[3:1];
  assign unused_a0 = addr[0];

  // classify: IACK first, then by top address nibble
  always_comb begin
    region = RG_UNMAP;
    unique case (1'b1)
      iack:
        region = (lvl >= 3'd1 && lvl <= 3'd3)
               ? RG_IACK : RG_UNMAP;
      !iack && area == AREA_LOW:
        region = (boot | wr) ? RG_SRAM : RG_PROM;
      !iack && area == AREA_PROM:
        region = RG_PROM;
      !iack && area == AREA_IO:
        region = (addr[19:4] == 16'h0)
               ? RG_IO : RG_UNMAP;
      default:
        region = RG_UNMAP;
    endcase
  end

endmodule

// File: rtl/bus_cycle_sequencer.sv
// 68000 bus cycle sequencer: classify, wait,
// single-step gate, then DTACK / AVEC / BERR.
module bus_cycle_sequencer
  import bus_pkg::*;
#(
  parameter int SRAM_WAIT      = 0,
  parameter int PROM_WAIT      = 2,
  parameter int IO_WAIT        = 1,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input logic CPUCLK_IN,
  input logic RESET_IN,
  bus_cycle_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             strobe;
  logic [2:0]       state;
  region_t          region_d;
  region_t          region_q;
  logic [CNT_W-1:0] wcnt;
  logic [CNT_W-1:0] tcnt;
  logic [CNT_W-1:0] wload;
  logic             armed;
  logic             step_q;
  logic             step_edge;
  logic             tmo;
  logic             wait_done;
  logic             data_ack;
  logic             avec_ack;
  logic             berr_ack;
  logic             to_flag;

  assign strobe    = bus.AS_IN & (bus.UDS_IN | bus.LDS_IN);
  assign step_edge = bus.STEP_IN & ~step_q;
  assign tmo       = (tcnt == TMO_LAST);
  assign wait_done = (wcnt == '0) &&
                     (region_q != RG_IO || bus.DEV_READY_IN);

  bus_region_decoder u_dec (
    .addr   (bus.ADDR_IN),
    .fc     (bus.MPU_STATUS_CODE_IN),
    .wr     (bus.WR_IN),
    .boot   (bus.BOOTSTRAPPED_IN),
    .region (region_d)
  );

  // per-region wait count loaded in DECODE
  always_comb begin
    wload = '0;
    unique case (1'b1)
      region_d == RG_SRAM: wload = CNT_W'(SRAM_WAIT);
      region_d == RG_PROM: wload = CNT_W'(PROM_WAIT);
      region_d == RG_IO:   wload = CNT_W'(IO_WAIT);
      default:             wload = '0;
    endcase
  end

  // step button history for 0->1 edge detection
  always_ff @(negedge CPUCLK_IN or posedge RESET_IN) begin
    if (RESET_IN) step_q <= 1'b0;
    else          step_q <= bus.STEP_IN;
  end

  // cycle FSM, wait/timeout counters, registered acks
  always_ff @(negedge CPUCLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      state    <= ST_IDLE;
      region_q <= RG_NONE;
      wcnt     <= '0;
      tcnt     <= '0;
      armed    <= 1'b0;
      data_ack <= 1'b0;
      avec_ack <= 1'b0;
      berr_ack <= 1'b0;
      to_flag  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          region_q <= RG_NONE;
          if (!strobe) begin
            armed <= 1'b1;
          end else if (armed) begin
            armed <= 1'b0;
            tcnt  <= '0;
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (!strobe) begin
            state    <= ST_IDLE;
            region_q <= RG_NONE;
          end else begin
            region_q <= region_d;
            wcnt     <= wload;
            tcnt     <= tcnt + CNT_ONE;
            if (region_d == RG_UNMAP) begin
              state <= ST_BERR;
            end else if (tmo) begin
              state   <= ST_BERR;
              to_flag <= 1'b1;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!strobe) begin
            state    <= ST_IDLE;
            region_q <= RG_NONE;
          end else if (tmo) begin
            state   <= ST_BERR;
            to_flag <= 1'b1;
          end else if (wait_done) begin
            if (bus.STEPEN_IN) begin
              state <= ST_STEP;
            end else begin
              state    <= ST_ACK;
              data_ack <= (region_q != RG_IACK);
              avec_ack <= (region_q == RG_IACK);
            end
          end else begin
            tcnt <= tcnt + CNT_ONE;
            if (wcnt != '0) wcnt <= wcnt - CNT_ONE;
          end
        end
        ST_STEP: begin
          if (!strobe) begin
            state    <= ST_IDLE;
            region_q <= RG_NONE;
          end else if (step_edge) begin
            state    <= ST_ACK;
            data_ack <= (region_q != RG_IACK);
            avec_ack <= (region_q == RG_IACK);
          end
        end
        ST_ACK: begin
          if (!strobe) begin
            data_ack <= 1'b0;
            avec_ack <= 1'b0;
            state    <= ST_IDLE;
            region_q <= RG_NONE;
          end
        end
        ST_BERR: begin
          if (strobe) begin
            berr_ack <= 1'b1;
          end else begin
            berr_ack <= 1'b0;
            state    <= ST_IDLE;
            region_q <= RG_NONE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.DATA_ACK        = data_ack;
  assign bus.INT_AUTOVEC_ACK = avec_ack;
  assign bus.BUS_ERROR_ACK   = berr_ack;
  assign bus.CYCLE_REGION    = region_q;
  assign bus.TIMEOUT_FLAG    = to_flag;

endmodule

// File: doc/bus_cycle_sequencer.md
Name: bus_cycle_sequencer

Overview:
Sequences every 68000 bus cycle on the board: classifies the cycle (SRAM, PROM, I/O, interrupt acknowledge, unmapped) and inserts per-region wait states. It applies single-step gating, then issues DTACK, AVEC or BERR to the CPU. It replaces the ad-hoc acknowledge OR-tree in the bus controller and adds an I/O ready handshake with a bus timeout.

Parameters:
SRAM_WAIT, 0, wait cycles before acknowledging an SRAM cycle
PROM_WAIT, 2, wait cycles before acknowledging a PROM cycle
IO_WAIT, 1, minimum wait cycles before acknowledging an I/O cycle
TIMEOUT_CYCLES, 64, cycles from cycle start to BERR if the cycle is not yet acknowledged
CNT_W, 8, width of the wait and timeout counters; must satisfy TIMEOUT_CYCLES < 2**CNT_W

Ports:
CPUCLK_IN  in  1  CPU clock; all state updates on the falling edge
RESET_IN  in  1  asynchronous, active-high reset
AS_IN  in  1  address strobe, 1 = asserted
UDS_IN  in  1  upper data strobe, 1 = asserted
LDS_IN  in  1  lower data strobe, 1 = asserted
WR_IN  in  1  1 = write cycle
ADDR_IN  in  24  CPU address
MPU_STATUS_CODE_IN  in  3  FC2..FC0
BOOTSTRAPPED_IN  in  1  1 = low area maps to SRAM for reads
DEV_READY_IN  in  1  selected I/O device has data or has accepted the write
STEPEN_IN  in  1  single-step mode enable
STEP_IN  in  1  step push button, already debounced
DATA_ACK  out  1  DTACK
INT_AUTOVEC_ACK  out  1  AVEC
BUS_ERROR_ACK  out  1  BERR
CYCLE_REGION  out  3  region of the current cycle: 0 none, 1 SRAM, 2 PROM, 3 IO, 4 IACK, 5 unmapped
TIMEOUT_FLAG  out  1  sticky; set on timeout, cleared only by reset

Behaviour:
- Reset (async, RESET_IN=1): state IDLE, all outputs 0, counters 0, STEP edge register 0.
- STROBE = AS_IN & (UDS_IN | LDS_IN). IACK = (MPU_STATUS_CODE_IN == 3'b111).
- IDLE: when STROBE=1 at a falling edge, go to DECODE. The timeout counter clears and starts counting from DECODE.
- DECODE (1 cycle): classify the cycle, set CYCLE_REGION, load the wait counter.
  - IACK: level ADDR_IN[3:1] in 1..3 gives IACK, otherwise unmapped.
  - ADDR[23:20]=0x0: SRAM if BOOTSTRAPPED_IN or WR_IN, else PROM.
  - ADDR[23:20]=0xF: PROM.
  - ADDR[23:20]=0x1 and ADDR[19:4]=0: IO.
  - Anything else: unmapped, go directly to BERR.
- WAIT: decrement the wait counter each cycle. At 0, leave WAIT:
  - IO stays in WAIT until DEV_READY_IN=1.
  - SRAM, PROM and IACK ignore DEV_READY_IN.
  - Exit to STEP if STEPEN_IN=1, else to ACK.
- Wait count 0 leaves WAIT on the first WAIT cycle. Latency from STROBE sampled to DATA_ACK asserted = 2 + wait cycles (SRAM_WAIT=0 gives DTACK 2 falling edges after the strobe is seen).
- STEP: hold until a 0->1 edge of STEP_IN, then go to ACK. The timeout counter is frozen in STEP, so a held single-step never produces BERR.
- ACK: assert DATA_ACK, or INT_AUTOVEC_ACK for IACK. Hold it until STROBE=0, then clear the ack and go to IDLE (registered, one edge later).
- BERR: assert BUS_ERROR_ACK until STROBE=0, then go to IDLE.
- Timeout: in DECODE or WAIT, when the timeout counter reaches TIMEOUT_CYCLES-1, go to BERR and set TIMEOUT_FLAG. Timeout takes priority over WAIT exit in the same cycle.
- Abort: STROBE dropping in DECODE, WAIT or STEP sends the block to IDLE with no ack.
- CYCLE_REGION: returns to 0 in IDLE.
- Output exclusivity: at most one of DATA_ACK, INT_AUTOVEC_ACK, BUS_ERROR_ACK is 1 at any time.
- Back-to-back cycles: a new STROBE is only recognised after one IDLE cycle with STROBE=0, so no acknowledge is ever carried across cycles.
- Reset mid-operation: immediate return to IDLE, all outputs 0.

Decomposition:
- Shared package bus_pkg:
  - State encoding: IDLE, DECODE, WAIT, STEP, ACK, BERR.
  - Region codes 0..5.
  - Address constants: area nibbles 0x0, 0x1, 0xF; IACK code 3'b111.
- One natural sub-module, bus_region_decoder: combinational classification of address, FC, WR and BOOTSTRAPPED into a region code. It is reusable by the chip-select logic.
- Counters and FSM stay in bus_cycle_sequencer.

Test Plan:
- SRAM read 0x000100, BOOTSTRAPPED_IN=1, STEPEN=0 -> CYCLE_REGION=1; DATA_ACK rises 2 edges after STROBE; drops 1 edge after AS falls.
- PROM read 0xF00000 -> DATA_ACK after 4 edges; reset pulse during WAIT -> all outputs 0 immediately, state IDLE.
- IO read 0x100007 with DEV_READY_IN=0 for 10 cycles then 1 -> DATA_ACK 1 edge after ready. With ready held 0 -> BUS_ERROR_ACK at cycle 64 and TIMEOUT_FLAG=1, which persists after the next good cycle.
- IACK (FC=111) with ADDR[3:1]=2 -> INT_AUTOVEC_ACK only. With ADDR[3:1]=5 -> BUS_ERROR_ACK and CYCLE_REGION=5.
- Unmapped write 0x500000 -> BUS_ERROR_ACK 2 edges after STROBE, no DATA_ACK.
- STEPEN=1, SRAM cycle held 200 cycles with no STEP -> no ack and no BERR. STEP edge -> DATA_ACK next edge. STROBE dropped while in STEP -> IDLE with no ack.
